cfu_issue_unit: RTL and testbench

Core-side initiator for the `cfu_interface` custom-function-unit protocol. It accepts issued CFU instructions from the execute stage, drives CFU requests with tagged IDs and bounded outstanding count, and buffers returned responses for in-order writeback. It checks each response against the expected ID and status, and flags responders that stall. It sits between the core issue/writeback logic and any CFU responder, such as the CRC unit.

---
 rtl/cfu_issue_pkg.sv | 19 +
 rtl/cfu_interface.sv | 28 ++
 rtl/cfu_sync_fifo.sv | 64 ++++++
 rtl/cfu_issue_unit.sv | 162 ++++++++++++++++
 tb/tb_cfu_issue_unit.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cfu_issue_pkg.sv
// Shared types and sizing helpers for the CFU issue unit.
package cfu_issue_pkg;

  localparam int CFU_ID_W = 4;

  typedef struct packed {
    logic [CFU_ID_W-1:0] id;
    logic [31:0]         data;
    logic                err;
  } cfu_resp_entry_t;

  localparam int CFU_RESP_W = $bits(cfu_resp_entry_t);

  // Credit counter must hold the value MAX_OUT itself, hence the extra bit.
  function automatic int inflight_w(input int max_out);
    return $clog2(max_out) + 1;
  endfunction

endpackage

// File: rtl/cfu_interface.sv
// Custom-function-unit request/response channel between a core initiator and a CFU responder.
// Both channels use valid/ready: a beat transfers on a cycle where valid and ready are both high,
// and the sender holds valid and payload stable until that cycle.
interface cfu_interface #(
  parameter int ID_W     = 4,
  parameter int STATUS_W = 2
);
  logic                req_valid;
  logic                req_ready;
  logic [ID_W-1:0]     req_id;
  logic [31:0]         req_data0;
  logic [31:0]         req_data1;
  logic                resp_valid;
  logic                resp_ready;
  logic [ID_W-1:0]     resp_id;
  logic [STATUS_W-1:0] resp_status;
  logic [31:0]         resp_data;

  modport initiator (
    output req_valid, req_id, req_data0, req_data1, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_status, resp_data
  );

  modport responder (
    input  req_valid, req_id, req_data0, req_data1, resp_ready,
    output req_ready, resp_valid, resp_id, resp_status, resp_data
  );
endinterface

// File: rtl/cfu_sync_fifo.sv
// Registered synchronous FIFO; DEPTH must be a power of two. Push when full and pop when empty are ignored.
module cfu_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         pop_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o     = (count_q == DEPTH_C);
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign pop_data_o = mem_q[rd_ptr_q];
  assign push_ok    = push_i & ~full_o;
  assign pop_ok     = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: reads are qualified by empty_o.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/cfu_issue_unit.sv
// Core-side CFU initiator: credit-limited tagged requests, in-order response buffering,
// expected-ID checking and a responder stall watchdog.
module cfu_issue_unit
  import cfu_issue_pkg::*;
#(
  parameter int ID_W    = CFU_ID_W,
  parameter int MAX_OUT = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [ID_W-1:0]   issue_id,
  input  logic [31:0]       issue_rs1,
  input  logic [31:0]       issue_rs2,
  cfu_interface.initiator   cfu,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [ID_W-1:0]   wb_id,
  output logic [31:0]       wb_data,
  output logic              wb_err,
  input  logic              clr_err,
  output logic              id_err,
  output logic              timeout_err
);

  localparam int IW = inflight_w(MAX_OUT);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IW-1:0] MAX_OUT_C = IW'(MAX_OUT);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);

  logic              req_valid_q, req_valid_d;
  logic [ID_W-1:0]   req_id_q, req_id_d;
  logic [31:0]       req_data0_q, req_data0_d;
  logic [31:0]       req_data1_q, req_data1_d;
  logic [IW-1:0]     inflight_q, inflight_d;
  logic [TW-1:0]     to_cnt_q, to_cnt_d;
  logic              id_err_q, id_err_d;
  logic              to_err_q, to_err_d;

  logic              issue_hs, req_hs, resp_hs, wb_hs;
  logic              id_mismatch, resp_err, to_set;

  logic [ID_W-1:0]   exp_head;
  logic              exp_full, exp_empty;
  logic [IW-1:0]     exp_count;
  cfu_resp_entry_t   resp_in, resp_head;
  logic              resp_full, resp_empty;
  logic [IW-1:0]     resp_count;
  logic              unused_fifo_status;

  assign issue_ready = (inflight_q < MAX_OUT_C) & (~req_valid_q | cfu.req_ready);
  assign issue_hs    = issue_valid & issue_ready;
  assign req_hs      = req_valid_q & cfu.req_ready;
  assign resp_hs     = cfu.resp_valid & cfu.resp_ready;
  assign wb_hs       = wb_valid & wb_ready;

  // A response with nothing outstanding (e.g. right after reset) is an orphan and counts as a mismatch.
  assign id_mismatch = exp_empty | (cfu.resp_id != exp_head);
  assign resp_err    = (cfu.resp_status != '0) | id_mismatch;
  assign resp_in     = '{id: cfu.resp_id, data: cfu.resp_data, err: resp_err};

  cfu_sync_fifo #(.WIDTH(ID_W), .DEPTH(MAX_OUT)) u_exp_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (req_hs),
    .push_data_i (req_id_q),
    .pop_i       (resp_hs),
    .pop_data_o  (exp_head),
    .full_o      (exp_full),
    .empty_o     (exp_empty),
    .count_o     (exp_count)
  );

  cfu_sync_fifo #(.WIDTH(CFU_RESP_W), .DEPTH(MAX_OUT)) u_resp_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (resp_hs),
    .push_data_i (resp_in),
    .pop_i       (wb_hs),
    .pop_data_o  (resp_head),
    .full_o      (resp_full),
    .empty_o     (resp_empty),
    .count_o     (resp_count)
  );

  assign unused_fifo_status = ^{exp_full, exp_count, resp_count};

  always_comb begin
    req_valid_d = req_valid_q;
    req_id_d    = req_id_q;
    req_data0_d = req_data0_q;
    req_data1_d = req_data1_q;
    inflight_d  = inflight_q;
    to_cnt_d    = to_cnt_q;
    id_err_d    = id_err_q;
    to_err_d    = to_err_q;

    if (issue_hs) begin
      req_valid_d = 1'b1;
      req_id_d    = issue_id;
      req_data0_d = issue_rs1;
      req_data1_d = issue_rs2;
    end else if (req_hs) begin
      req_valid_d = 1'b0;
    end

    // Orphan writebacks never took a credit, so the counter must not underflow on them.
    case ({issue_hs, wb_hs && (inflight_q != '0)})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase

    if (resp_hs || exp_empty)     to_cnt_d = '0;
    else if (to_cnt_q != TO_LAST) to_cnt_d = to_cnt_q + 1'b1;
    to_set = (to_cnt_q != TO_LAST) && (to_cnt_d == TO_LAST);

    if (resp_hs && id_mismatch) id_err_d = 1'b1;
    else if (clr_err)           id_err_d = 1'b0;

    if (to_set)       to_err_d = 1'b1;
    else if (clr_err) to_err_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_valid_q <= 1'b0;
      req_id_q    <= '0;
      req_data0_q <= '0;
      req_data1_q <= '0;
      inflight_q  <= '0;
      to_cnt_q    <= '0;
      id_err_q    <= 1'b0;
      to_err_q    <= 1'b0;
    end else begin
      req_valid_q <= req_valid_d;
      req_id_q    <= req_id_d;
      req_data0_q <= req_data0_d;
      req_data1_q <= req_data1_d;
      inflight_q  <= inflight_d;
      to_cnt_q    <= to_cnt_d;
      id_err_q    <= id_err_d;
      to_err_q    <= to_err_d;
    end
  end

  assign cfu.req_valid  = req_valid_q;
  assign cfu.req_id     = req_id_q;
  assign cfu.req_data0  = req_data0_q;
  assign cfu.req_data1  = req_data1_q;
  assign cfu.resp_ready = ~resp_full;

  assign wb_valid    = ~resp_empty;
  assign wb_id       = wb_valid ? resp_head.id   : '0;
  assign wb_data     = wb_valid ? resp_head.data : '0;
  assign wb_err      = wb_valid & resp_head.err;
  assign id_err      = id_err_q;
  assign timeout_err = to_err_q;

endmodule

// File: tb/tb_cfu_issue_unit.sv
// Directed bench for cfu_issue_unit: responses are queued as expected writebacks and checked by a monitor.
module tb_cfu_issue_unit;
  localparam int ID_W    = 4;
  localparam int MAX_OUT = 4;
  localparam int TIMEOUT = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            issue_valid;
  logic            issue_ready;
  logic [ID_W-1:0] issue_id;
  logic [31:0]     issue_rs1, issue_rs2;
  logic            wb_valid, wb_ready;
  logic [ID_W-1:0] wb_id;
  logic [31:0]     wb_data;
  logic            wb_err;
  logic            clr_err;
  logic            id_err, timeout_err;

  cfu_interface #(.ID_W(ID_W)) cfu_if ();

  cfu_issue_unit #(.ID_W(ID_W), .MAX_OUT(MAX_OUT), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .issue_id    (issue_id),
    .issue_rs1   (issue_rs1),
    .issue_rs2   (issue_rs2),
    .cfu         (cfu_if),
    .wb_valid    (wb_valid),
    .wb_ready    (wb_ready),
    .wb_id       (wb_id),
    .wb_data     (wb_data),
    .wb_err      (wb_err),
    .clr_err     (clr_err),
    .id_err      (id_err),
    .timeout_err (timeout_err)
  );

  // clock/reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  int checks   = 0;
  int failures = 0;
  int req_hs_cnt = 0;
  logic [ID_W+32:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [ID_W+32:0] e;
    if (rst_n && cfu_if.req_valid && cfu_if.req_ready) req_hs_cnt++;
    if (rst_n && wb_valid && wb_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL wb_unexpected got=0x%0h exp=none", {wb_id, wb_data, wb_err});
      end else begin
        e = exp_q.pop_front();
        if ({wb_id, wb_data, wb_err} !== e) begin
          failures++;
          $display("FAIL wb_entry got=0x%0h exp=0x%0h", {wb_id, wb_data, wb_err}, e);
        end
      end
    end
  end

  // driver tasks
  task automatic do_issue(input logic [ID_W-1:0] id, input logic [31:0] rs1, input logic [31:0] rs2);
    bit ok = 0;
    issue_valid = 1'b1;
    issue_id    = id;
    issue_rs1   = rs1;
    issue_rs2   = rs2;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = issue_ready;
      tick();
    end
    issue_valid = 1'b0;
    if (!ok) check("issue_accept_bound", 64'd0, 64'd1);
  endtask

  task automatic send_resp(input logic [ID_W-1:0] id, input logic [1:0] status,
                           input logic [31:0] data, input logic exp_err);
    bit ok = 0;
    cfu_if.resp_valid  = 1'b1;
    cfu_if.resp_id     = id;
    cfu_if.resp_status = status;
    cfu_if.resp_data   = data;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = cfu_if.resp_ready;
      if (ok) exp_q.push_back({id, data, exp_err});
      tick();
    end
    cfu_if.resp_valid = 1'b0;
    if (!ok) check("resp_accept_bound", 64'd0, 64'd1);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_req_valid"},   cfu_if.req_valid, 0);
    check({tag, "_req_id"},      cfu_if.req_id, 0);
    check({tag, "_req_data0"},   cfu_if.req_data0, 0);
    check({tag, "_req_data1"},   cfu_if.req_data1, 0);
    check({tag, "_resp_ready"},  cfu_if.resp_ready, 1);
    check({tag, "_wb_valid"},    wb_valid, 0);
    check({tag, "_wb_id"},       wb_id, 0);
    check({tag, "_wb_data"},     wb_data, 0);
    check({tag, "_wb_err"},      wb_err, 0);
    check({tag, "_id_err"},      id_err, 0);
    check({tag, "_timeout_err"}, timeout_err, 0);
    check({tag, "_issue_ready"}, issue_ready, 1);
  endtask

  initial begin
    int accepted;
    int hs_before;
    bit pend;
    logic [ID_W-1:0] pend_id;
    logic [ID_W-1:0] iq[$];
    logic [31:0] rdata;

    rst_n = 1'b0;
    issue_valid = 1'b0; issue_id = '0; issue_rs1 = '0; issue_rs2 = '0;
    wb_ready = 1'b0; clr_err = 1'b0;
    cfu_if.req_ready = 1'b0; cfu_if.resp_valid = 1'b0;
    cfu_if.resp_id = '0; cfu_if.resp_status = '0; cfu_if.resp_data = '0;
    repeat (3) tick();
    @(negedge clk);
    check_reset("rst");
    tick();
    rst_n = 1'b1;
    tick();

    // single op
    cfu_if.req_ready = 1'b1;
    wb_ready = 1'b1;
    do_issue(4'd3, 32'hFFFF_FFFF, 32'h0000_0061);
    @(negedge clk);
    check("single_req_valid", cfu_if.req_valid, 1);
    check("single_req_id",    cfu_if.req_id, 3);
    check("single_req_data0", cfu_if.req_data0, 64'hFFFF_FFFF);
    check("single_req_data1", cfu_if.req_data1, 64'h61);
    tick();
    cfu_if.resp_valid = 1'b1; cfu_if.resp_id = 4'd3;
    cfu_if.resp_status = 2'd0; cfu_if.resp_data = 32'h1234_5678;
    exp_q.push_back({4'd3, 32'h1234_5678, 1'b0});
    @(negedge clk);
    check("single_req_cleared", cfu_if.req_valid, 0);
    check("single_resp_ready",  cfu_if.resp_ready, 1);
    check("single_wb_not_comb", wb_valid, 0);
    tick();
    cfu_if.resp_valid = 1'b0;
    @(negedge clk);
    check("single_wb_valid", wb_valid, 1);
    tick();

    // back-pressure on the request channel
    cfu_if.req_ready = 1'b0;
    hs_before = req_hs_cnt;
    do_issue(4'd1, 32'h0000_000A, 32'h0000_000B);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_req_valid",   cfu_if.req_valid, 1);
      check("bp_req_id",      cfu_if.req_id, 1);
      check("bp_req_data0",   cfu_if.req_data0, 64'hA);
      check("bp_req_data1",   cfu_if.req_data1, 64'hB);
      check("bp_issue_ready", issue_ready, 0);
      tick();
    end
    cfu_if.req_ready = 1'b1;
    tick();
    @(negedge clk);
    check("bp_req_cleared", cfu_if.req_valid, 0);
    tick();
    check("bp_single_hs", req_hs_cnt - hs_before, 1);
    send_resp(4'd1, 2'd0, 32'h0000_BEEF, 1'b0);
    repeat (2) tick();

    // credit limit with an instant responder and stalled writeback
    wb_ready = 1'b0;
    accepted = 0;
    pend = 0;
    pend_id = '0;
    for (int c = 0; c < 12; c++) begin
      issue_valid = (accepted < 8);
      issue_id    = 4'(8 + accepted);
      issue_rs1   = 32'(c);
      issue_rs2   = ~32'(c);
      if (pend) begin
        rdata = 32'hC0DE_0000 | 32'(pend_id);
        cfu_if.resp_valid = 1'b1; cfu_if.resp_id = pend_id;
        cfu_if.resp_status = 2'd0; cfu_if.resp_data = rdata;
        exp_q.push_back({pend_id, rdata, 1'b0});
      end else begin
        cfu_if.resp_valid = 1'b0;
      end
      @(negedge clk);
      if (pend) check("credit_resp_ready", cfu_if.resp_ready, 1);
      if (issue_valid && issue_ready) begin
        accepted++;
        iq.push_back(issue_id);
      end
      pend = cfu_if.req_valid && cfu_if.req_ready && (iq.size() > 0);
      if (pend) pend_id = iq.pop_front();
      tick();
    end
    issue_valid = 1'b0;
    cfu_if.resp_valid = 1'b0;
    @(negedge clk);
    check("credit_accepted",    accepted, MAX_OUT);
    check("credit_issue_ready", issue_ready, 0);
    check("credit_wb_valid",    wb_valid, 1);
    tick();
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    @(negedge clk);
    check("credit_freed", issue_ready, 1);
    tick();
    wb_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    check("credit_drain", exp_q.size(), 0);

    // ID mismatch: responses come back swapped
    do_issue(4'd5, 32'h5, 32'h50);
    do_issue(4'd6, 32'h6, 32'h60);
    repeat (2) tick();
    send_resp(4'd6, 2'd0, 32'h0000_0066, 1'b1);
    send_resp(4'd5, 2'd0, 32'h0000_0055, 1'b1);
    repeat (2) tick();
    @(negedge clk);
    check("mismatch_id_err", id_err, 1);
    tick();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    @(negedge clk);
    check("mismatch_clr", id_err, 0);
    tick();

    // error status with the correct id
    do_issue(4'd7, 32'h7, 32'h70);
    tick();
    send_resp(4'd7, 2'd1, 32'h0000_0077, 1'b1);
    repeat (2) tick();
    @(negedge clk);
    check("status_no_id_err", id_err, 0);
    tick();

    // silent responder
    do_issue(4'd2, 32'h2, 32'h20);
    repeat (13) tick();
    @(negedge clk);
    check("timeout_early", timeout_err, 0);
    repeat (4) tick();
    @(negedge clk);
    check("timeout_set", timeout_err, 1);
    tick();
    send_resp(4'd2, 2'd0, 32'h0000_1A7E, 1'b0);
    repeat (2) tick();
    @(negedge clk);
    check("timeout_sticky", timeout_err, 1);
    tick();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    @(negedge clk);
    check("timeout_clr", timeout_err, 0);
    tick();

    // reset with a buffered response and one request outstanding
    wb_ready = 1'b0;
    do_issue(4'd4, 32'h4, 32'h40);
    tick();
    send_resp(4'd4, 2'd0, 32'h0000_0044, 1'b0);
    do_issue(4'd5, 32'h5, 32'h50);
    @(negedge clk);
    check("midrst_pending_wb", wb_valid, 1);
    tick();
    exp_q.delete();
    rst_n = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    check_reset("midrst");
    tick();
    rst_n = 1'b1;
    wb_ready = 1'b1;
    send_resp(4'd9, 2'd0, 32'h0000_0099, 1'b1);
    tick();
    @(negedge clk);
    check("orphan_id_err", id_err, 1);
    tick();

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
    check("final_drain", exp_q.size(), 0);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
